// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder: counts spikes per channel over a programmable window and
// publishes the counts on a valid/ready port at each window end.
module spike_rate_decoder #(
  parameter int N_CH  = 2,
  parameter int CNT_W = 8,
  parameter int WIN_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic [N_CH-1:0]       spike_in,
  input  logic [WIN_W-1:0]      win_len,
  output logic [N_CH*CNT_W-1:0] rate_out,
  output logic                  rate_valid,
  input  logic                  rate_ready,
  output logic [N_CH-1:0]       sat,
  output logic                  overrun
);
  typedef enum logic {IDLE, COUNT} state_t;
  state_t state, state_nx;
  logic [WIN_W-1:0] wl_q, win_cnt;
  logic [N_CH-1:0][CNT_W-1:0] cnt_q, cnt_nx;
  logic [N_CH-1:0] sat_q, sat_nx;
  logic win_end, load;

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;

  // Both states leave for COUNT while enabled; dropping ena always returns to IDLE.
  always_comb state_nx = ena ? COUNT : IDLE;

  always_comb begin
    win_end = (state == COUNT) && (win_cnt == wl_q - WIN_W'(1));
    load = ena && ((state == IDLE) || win_end);
  end

  // The current cycle's spike is folded in here so a window end publishes it too.
  always_comb begin
    cnt_nx = cnt_q;
    sat_nx = sat_q;
    for (int i = 0; i < N_CH; i++) begin
      cnt_nx[i] = (spike_in[i] && !(&cnt_q[i])) ? cnt_q[i] + CNT_W'(1) : cnt_q[i];
      sat_nx[i] = sat_q[i] | (&cnt_nx[i]);
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wl_q <= '0;
      win_cnt <= '0;
      cnt_q <= '0;
      sat_q <= '0;
      rate_out <= '0;
      rate_valid <= 1'b0;
      sat <= '0;
      overrun <= 1'b0;
    end else begin
      if (load) begin
        wl_q <= (win_len == '0) ? WIN_W'(1) : win_len;
        win_cnt <= '0;
        cnt_q <= '0;
        sat_q <= '0;
      end else if (state == COUNT) begin
        win_cnt <= win_cnt + WIN_W'(1);
        cnt_q <= cnt_nx;
        sat_q <= sat_nx;
      end
      if (win_end) begin
        rate_out <= cnt_nx;
        sat <= sat_nx;
        rate_valid <= 1'b1;
        if (rate_valid && !rate_ready) overrun <= 1'b1;
      end else if (rate_valid && rate_ready) rate_valid <= 1'b0;
    end
endmodule

// File: tb/tb_spike_rate_decoder.sv
// tb_spike_rate_decoder: table-driven single windows plus hand-written multi-cycle
// sequences for back-to-back windows, overrun, ena drop and async reset.
module tb_spike_rate_decoder;
  logic clk = 1'b0;
  logic rst, ena, rate_ready, rate_valid, overrun;
  logic [1:0] spike_in, sat;
  logic [7:0] win_len;
  logic [15:0] rate_out;
  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0]  wl;
    logic [31:0] p0;
    logic [31:0] p1;
    logic [7:0]  e0;
    logic [7:0]  e1;
    logic [1:0]  es;
  } vec_t;
  vec_t vecs[6];

  spike_rate_decoder #(.N_CH(2), .CNT_W(8), .WIN_W(8)) dut (
    .clk(clk), .rst(rst), .ena(ena), .spike_in(spike_in), .win_len(win_len),
    .rate_out(rate_out), .rate_valid(rate_valid), .rate_ready(rate_ready),
    .sat(sat), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int eff;
    eff = (v.wl == 0) ? 1 : int'(v.wl);
    win_len = v.wl;
    ena = 1'b1;
    spike_in = 2'b00;
    step();
    for (int k = 0; k < eff; k++) begin
      spike_in = {v.p1[k], v.p0[k]};
      ena = (k != eff - 1);
      step();
      if (k < eff - 1) chk("vec_valid_early", rate_valid, 1'b0);
    end
    chk("vec_valid", rate_valid, 1'b1);
    chk("vec_ch0", rate_out[7:0], v.e0);
    chk("vec_ch1", rate_out[15:8], v.e1);
    chk("vec_sat", sat, v.es);
    spike_in = 2'b00;
    rate_ready = 1'b1;
    step();
    chk("vec_consumed", rate_valid, 1'b0);
    rate_ready = 1'b0;
  endtask

  initial begin
    vecs[0] = '{wl: 8'd10, p0: 32'h209,  p1: 32'h0,    e0: 8'd3,  e1: 8'd0, es: 2'b00};
    vecs[1] = '{wl: 8'd4,  p0: 32'hF,    p1: 32'h5,    e0: 8'd4,  e1: 8'd2, es: 2'b00};
    vecs[2] = '{wl: 8'd0,  p0: 32'h1,    p1: 32'h0,    e0: 8'd1,  e1: 8'd0, es: 2'b00};
    vecs[3] = '{wl: 8'd1,  p0: 32'h0,    p1: 32'h1,    e0: 8'd0,  e1: 8'd1, es: 2'b00};
    vecs[4] = '{wl: 8'd16, p0: 32'hFFFF, p1: 32'hAAAA, e0: 8'd16, e1: 8'd8, es: 2'b00};
    vecs[5] = '{wl: 8'd3,  p0: 32'h5,    p1: 32'h7,    e0: 8'd2,  e1: 8'd3, es: 2'b00};

    rst = 1'b1; ena = 1'b0; spike_in = 2'b00; win_len = 8'd0; rate_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("rst_rate_out", rate_out, 16'h0);
    chk("rst_valid", rate_valid, 1'b0);
    chk("rst_sat", sat, 2'b00);
    chk("rst_overrun", overrun, 1'b0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Back-to-back windows of 4, result every 4 cycles
    rate_ready = 1'b1; win_len = 8'd4; ena = 1'b1; spike_in = 2'b10;
    step();
    for (int w = 0; w < 3; w++)
      for (int c = 0; c < 4; c++) begin
        step();
        if (c == 3) begin
          chk("b2b_valid", rate_valid, 1'b1);
          chk("b2b_ch1", rate_out[15:8], 8'd4);
          chk("b2b_ch0", rate_out[7:0], 8'd0);
        end else chk("b2b_gap", rate_valid, 1'b0);
      end
    chk("b2b_overrun", overrun, 1'b0);
    ena = 1'b0; spike_in = 2'b00;
    step();
    chk("b2b_drain", rate_valid, 1'b0);

    // Window of 1: transfer and window end coincide every cycle
    win_len = 8'd1; ena = 1'b1;
    step();
    for (int k = 0; k < 4; k++) begin
      spike_in = {1'b0, k[0]};
      step();
      chk("w1_valid", rate_valid, 1'b1);
      chk("w1_ch0", rate_out[7:0], {7'd0, k[0]});
    end
    chk("w1_overrun", overrun, 1'b0);
    ena = 1'b0; spike_in = 2'b00;
    step();
    chk("w1_last_valid", rate_valid, 1'b1);
    chk("w1_last_ch0", rate_out[7:0], 8'd0);
    step();
    chk("w1_drain", rate_valid, 1'b0);
    rate_ready = 1'b0;

    // Window of 255 with ch0 stuck high saturates ch0 only
    win_len = 8'd255; ena = 1'b1; spike_in = 2'b01;
    step();
    for (int k = 0; k < 255; k++) begin
      ena = (k != 254);
      step();
    end
    chk("sat_valid", rate_valid, 1'b1);
    chk("sat_ch0", rate_out[7:0], 8'd255);
    chk("sat_ch1", rate_out[15:8], 8'd0);
    chk("sat_bits", sat, 2'b01);
    spike_in = 2'b00; rate_ready = 1'b1;
    step();
    chk("sat_consumed", rate_valid, 1'b0);
    rate_ready = 1'b0;

    // Overrun: two windows with no consumer
    win_len = 8'd5; ena = 1'b1;
    step();
    spike_in = 2'b01;
    for (int k = 0; k < 5; k++) step();
    chk("ovr_first_valid", rate_valid, 1'b1);
    chk("ovr_first_ch0", rate_out[7:0], 8'd5);
    chk("ovr_first_flag", overrun, 1'b0);
    spike_in = 2'b00;
    for (int k = 0; k < 5; k++) begin
      ena = (k != 4);
      step();
    end
    chk("ovr_second_valid", rate_valid, 1'b1);
    chk("ovr_second_ch0", rate_out[7:0], 8'd0);
    chk("ovr_flag", overrun, 1'b1);
    rate_ready = 1'b1;
    step();
    chk("ovr_consumed", rate_valid, 1'b0);
    rate_ready = 1'b0;

    // ena dropped at window cycle 4 discards partial counts
    win_len = 8'd8; ena = 1'b1; spike_in = 2'b11;
    step();
    for (int k = 0; k < 4; k++) step();
    ena = 1'b0;
    step();
    chk("drop_valid", rate_valid, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("drop_idle_valid", rate_valid, 1'b0);
    end
    spike_in = 2'b01; ena = 1'b1;
    step();
    for (int k = 0; k < 8; k++) begin
      ena = (k != 7);
      step();
      if (k < 7) chk("fresh_valid_early", rate_valid, 1'b0);
    end
    chk("fresh_valid", rate_valid, 1'b1);
    chk("fresh_ch0", rate_out[7:0], 8'd8);
    chk("fresh_ch1", rate_out[15:8], 8'd0);
    chk("overrun_sticky", overrun, 1'b1);
    spike_in = 2'b00; rate_ready = 1'b1;
    step();
    chk("fresh_consumed", rate_valid, 1'b0);
    rate_ready = 1'b0;

    // Asynchronous reset mid-window while a result is pending
    win_len = 8'd10; ena = 1'b1; spike_in = 2'b01;
    step();
    for (int k = 0; k < 10; k++) step();
    chk("prerst_valid", rate_valid, 1'b1);
    for (int k = 0; k < 3; k++) step();
    #2 rst = 1'b1;
    #1;
    chk("arst_rate_out", rate_out, 16'h0);
    chk("arst_valid", rate_valid, 1'b0);
    chk("arst_sat", sat, 2'b00);
    chk("arst_overrun", overrun, 1'b0);
    #2 rst = 1'b0;
    win_len = 8'd2; spike_in = 2'b10;
    step();
    step();
    chk("post_rst_early", rate_valid, 1'b0);
    ena = 1'b0;
    step();
    chk("post_rst_valid", rate_valid, 1'b1);
    chk("post_rst_ch1", rate_out[15:8], 8'd2);
    chk("post_rst_ch0", rate_out[7:0], 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
